alu_exec_stage: RTL and testbench

//  Registered execute stage around the unsigned ripple adder: accepts an ALU op plus operands over a

---
 rtl/alu_pkg.sv | 17 +
 rtl/alu_uadd.sv | 13 +
 rtl/alu_exec_stage.sv | 125 ++++++++++++
 tb/tb_alu_exec_stage.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU execute stage: op encodings and flag bit positions.
package alu_pkg;

    typedef enum logic [1:0] {
        ALU_ADD = 2'b00,
        ALU_ADC = 2'b01,
        ALU_SUB = 2'b10,
        ALU_SBC = 2'b11
    } alu_op_e;

    // Bit positions inside the {N,Z,C,V} flag vector.
    localparam int FLG_V = 0;
    localparam int FLG_C = 1;
    localparam int FLG_Z = 2;
    localparam int FLG_N = 3;

endpackage

// File: rtl/alu_uadd.sv
// Unsigned adder without carry-in; returns the SIZE-bit sum and the carry-out.
module alu_uadd #(
    parameter int SIZE = 8
) (
    input  logic [SIZE-1:0] a,
    input  logic [SIZE-1:0] b,
    output logic [SIZE-1:0] sum,
    output logic            cout
);

    assign {cout, sum} = {1'b0, a} + {1'b0, b};

endmodule

// File: rtl/alu_exec_stage.sv
// Two-register execute stage (input register S1, output register S2) adding ADC/SUB/SBC
// and an architectural carry flag on top of the carry-in-less unsigned adder.
module alu_exec_stage
    import alu_pkg::*;
#(
    parameter int SIZE  = 8,
    parameter int TAG_W = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [1:0]       i_op,
    input  logic [SIZE-1:0]  i_s1,
    input  logic [SIZE-1:0]  i_s2,
    input  logic [TAG_W-1:0] i_tag,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [SIZE-1:0]  o_result,
    output logic [3:0]       o_flags,
    output logic [TAG_W-1:0] o_tag
);

    // Handshake: a transfer happens on a rising edge where valid and ready are both 1.
    // The producer holds valid and data stable until that edge; ready may depend on
    // downstream ready combinationally (o_ready = !s1_valid | s2_load).
    logic             s1_valid;
    alu_op_e          s1_op;
    logic [SIZE-1:0]  s1_a;
    logic [SIZE-1:0]  s1_b;
    logic [TAG_W-1:0] s1_tag;
    logic             r_c;

    logic             s1_load;
    logic             s2_load;

    logic [SIZE-1:0]  b_prep;
    logic             cin;
    logic [SIZE-1:0]  partial;
    logic             carry0;
    logic [SIZE-1:0]  sum;
    logic             carry1;
    logic             carry;
    logic [3:0]       flags;

    assign s2_load = s1_valid & (~o_valid | i_ready);
    assign o_ready = ~s1_valid | s2_load;
    assign s1_load = i_valid & o_ready;

    // Subtraction is a + ~b + 1; SBC uses the stored carry as "no borrow".
    assign b_prep = s1_op[1] ? ~s1_b : s1_b;

    always_comb begin
        cin = 1'b0;
        case (s1_op)
            ALU_ADD: cin = 1'b0;
            ALU_ADC: cin = r_c;
            ALU_SUB: cin = 1'b1;
            ALU_SBC: cin = r_c;
            default: cin = 1'b0;
        endcase
    end

    alu_uadd #(.SIZE(SIZE)) u_add_ab (
        .a    (s1_a),
        .b    (b_prep),
        .sum  (partial),
        .cout (carry0)
    );

    alu_uadd #(.SIZE(SIZE)) u_add_cin (
        .a    (partial),
        .b    ({{(SIZE-1){1'b0}}, cin}),
        .sum  (sum),
        .cout (carry1)
    );

    assign carry = carry0 | carry1;

    always_comb begin
        flags        = 4'b0000;
        flags[FLG_N] = sum[SIZE-1];
        flags[FLG_Z] = (sum == '0);
        flags[FLG_C] = carry;
        flags[FLG_V] = (s1_a[SIZE-1] == b_prep[SIZE-1]) & (sum[SIZE-1] != s1_a[SIZE-1]);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            s1_valid <= 1'b0;
            s1_op    <= ALU_ADD;
            s1_a     <= '0;
            s1_b     <= '0;
            s1_tag   <= '0;
        end else if (s1_load) begin
            s1_valid <= 1'b1;
            s1_op    <= alu_op_e'(i_op);
            s1_a     <= i_s1;
            s1_b     <= i_s2;
            s1_tag   <= i_tag;
        end else if (s2_load) begin
            s1_valid <= 1'b0;
        end
    end

    // r_c changes on the same edge the op leaves S1, so a following ADC/SBC sees it directly.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_valid  <= 1'b0;
            o_result <= '0;
            o_flags  <= 4'b0000;
            o_tag    <= '0;
            r_c      <= 1'b0;
        end else if (s2_load) begin
            o_valid  <= 1'b1;
            o_result <= sum;
            o_flags  <= flags;
            o_tag    <= s1_tag;
            r_c      <= carry;
        end else if (i_ready) begin
            o_valid  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_exec_stage.sv
// Bench for alu_exec_stage: directed arithmetic cases, reset flush, backpressure and a random run.
module tb_alu_exec_stage;

  localparam int SIZE  = 8;
  localparam int TAG_W = 4;
  localparam int W     = SIZE + 4 + TAG_W;

  logic             i_clk   = 1'b0;
  logic             i_rst   = 1'b1;
  logic             i_valid = 1'b0;
  logic             o_ready;
  logic [1:0]       i_op    = 2'b00;
  logic [SIZE-1:0]  i_s1    = '0;
  logic [SIZE-1:0]  i_s2    = '0;
  logic [TAG_W-1:0] i_tag   = '0;
  logic             o_valid;
  logic             i_ready = 1'b0;
  logic [SIZE-1:0]  o_result;
  logic [3:0]       o_flags;
  logic [TAG_W-1:0] o_tag;

  logic [W-1:0] exp_q[$];
  int n_vec  = 0;
  int n_miss = 0;
  int n_out  = 0;
  int cyc    = 0;
  logic model_c = 1'b0;

  alu_exec_stage #(.SIZE(SIZE), .TAG_W(TAG_W)) dut (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_valid  (i_valid),
    .o_ready  (o_ready),
    .i_op     (i_op),
    .i_s1     (i_s1),
    .i_s2     (i_s2),
    .i_tag    (i_tag),
    .o_valid  (o_valid),
    .i_ready  (i_ready),
    .o_result (o_result),
    .o_flags  (o_flags),
    .o_tag    (o_tag)
  );

  // clock / cycle counter
  always #5 i_clk = ~i_clk;
  always @(posedge i_clk) cyc <= cyc + 1;

  // golden model: returns {result, N, Z, C, V}
  function automatic logic [SIZE+3:0] model(input logic [1:0] op, input logic [SIZE-1:0] a,
                                            input logic [SIZE-1:0] b, input logic c_prev);
    logic [SIZE-1:0] bp;
    logic            c_in;
    logic [SIZE:0]   full;
    logic [SIZE-1:0] r;
    logic            v;
    bp   = op[1] ? ~b : b;
    c_in = (op == 2'b00) ? 1'b0 : (op == 2'b10) ? 1'b1 : c_prev;
    full = {1'b0, a} + {1'b0, bp} + {{SIZE{1'b0}}, c_in};
    r    = full[SIZE-1:0];
    v    = (a[SIZE-1] == bp[SIZE-1]) && (r[SIZE-1] != a[SIZE-1]);
    return {r, r[SIZE-1], (r == '0), full[SIZE], v};
  endfunction

  // scoreboard: pops on every output handshake
  task automatic monitor();
    logic [W-1:0] got;
    logic [W-1:0] e;
    forever begin
      @(negedge i_clk);
      if (!i_rst && o_valid && i_ready) begin
        n_out++;
        n_vec++;
        got = {o_result, o_flags, o_tag};
        if (exp_q.size() == 0) begin
          n_miss++;
          $display("FAIL unexpected_output got=%h expected=none", got);
        end else begin
          e = exp_q.pop_front();
          if (got !== e) begin
            n_miss++;
            $display("FAIL result got res=%h flags=%b tag=%h expected res=%h flags=%b tag=%h",
                     o_result, o_flags, o_tag, e[W-1 -: SIZE], e[TAG_W+3 -: 4], e[TAG_W-1:0]);
          end
        end
      end
    end
  endtask

  // driver: holds the op until accepted, then pushes its expected result
  task automatic send_op(input logic [1:0] op, input logic [SIZE-1:0] a, input logic [SIZE-1:0] b,
                         input logic [TAG_W-1:0] tag, input logic [SIZE-1:0] exp_res,
                         input logic [3:0] exp_flags);
    bit acc = 0;
    int budget = 0;
    i_valid = 1'b1;
    i_op = op;
    i_s1 = a;
    i_s2 = b;
    i_tag = tag;
    while (!acc) begin
      @(negedge i_clk);
      if (o_ready) begin
        acc = 1;
        exp_q.push_back({exp_res, exp_flags, tag});
        model_c = exp_flags[1];
      end
      @(posedge i_clk);
      #1;
      budget++;
      if (!acc && budget > 50) begin
        n_vec++;
        n_miss++;
        $display("FAIL accept_timeout got o_ready=0 for %0d cycles expected=accept", budget);
        break;
      end
    end
    i_valid = 1'b0;
  endtask

  task automatic send_rand();
    logic [1:0]       op;
    logic [SIZE-1:0]  a;
    logic [SIZE-1:0]  b;
    logic [TAG_W-1:0] tag;
    logic [SIZE+3:0]  e;
    op  = 2'($urandom_range(0, 3));
    a   = SIZE'($urandom_range(0, 255));
    b   = SIZE'($urandom_range(0, 255));
    tag = TAG_W'($urandom_range(0, 15));
    e   = model(op, a, b, model_c);
    send_op(op, a, b, tag, e[SIZE+3:4], e[3:0]);
  endtask

  task automatic wait_drain(input int budget);
    int k = 0;
    while ((exp_q.size() != 0 || o_valid) && k < budget) begin
      @(posedge i_clk);
      #1;
      k++;
    end
    n_vec++;
    if (exp_q.size() != 0 || o_valid) begin
      n_miss++;
      $display("FAIL drain got pending=%0d o_valid=%b expected pending=0 o_valid=0",
               exp_q.size(), o_valid);
    end
  endtask

  task automatic test_reset();
    i_rst = 1'b1;
    repeat (3) @(posedge i_clk);
    #1;
    n_vec++;
    if ({o_valid, o_result, o_flags, o_tag} !== '0) begin
      n_miss++;
      $display("FAIL reset_state got v=%b res=%h flags=%b tag=%h expected all zero",
               o_valid, o_result, o_flags, o_tag);
    end
    i_rst = 1'b0;
    @(negedge i_clk);
    n_vec++;
    if (o_ready !== 1'b1) begin
      n_miss++;
      $display("FAIL reset_ready got=%b expected=1", o_ready);
    end
    @(posedge i_clk);
    #1;
  endtask

  task automatic test_reset_midstream();
    i_ready = 1'b0;
    send_op(2'b00, 8'hFF, 8'h01, 4'h1, 8'h00, 4'b0110);
    send_op(2'b00, 8'hFF, 8'h01, 4'h2, 8'h00, 4'b0110);
    i_rst = 1'b1;
    exp_q.delete();
    model_c = 1'b0;
    repeat (3) begin
      @(posedge i_clk);
      #1;
      n_vec++;
      if ({o_valid, o_result, o_flags, o_tag} !== '0) begin
        n_miss++;
        $display("FAIL reset_flush got v=%b res=%h flags=%b tag=%h expected all zero",
                 o_valid, o_result, o_flags, o_tag);
      end
    end
    i_rst = 1'b0;
    i_ready = 1'b1;
    repeat (3) begin
      @(negedge i_clk);
      n_vec++;
      if (o_valid !== 1'b0 || o_ready !== 1'b1) begin
        n_miss++;
        $display("FAIL reset_stale got o_valid=%b o_ready=%b expected o_valid=0 o_ready=1",
                 o_valid, o_ready);
      end
    end
    @(posedge i_clk);
    #1;
    // carry flag must have been cleared: ADC 0+0 gives 0
    send_op(2'b01, 8'h00, 8'h00, 4'h3, 8'h00, 4'b0100);
    wait_drain(10);
  endtask

  task automatic test_add_wrap();
    int c0;
    i_ready = 1'b1;
    c0 = cyc;
    send_op(2'b00, 8'hFF, 8'h01, 4'hA, 8'h00, 4'b0110);
    while (!o_valid && cyc - c0 < 10) begin
      @(posedge i_clk);
      #1;
    end
    n_vec++;
    if (cyc - c0 != 2) begin
      n_miss++;
      $display("FAIL latency got=%0d expected=2", cyc - c0);
    end
    wait_drain(10);
  endtask

  task automatic test_sub();
    i_ready = 1'b1;
    send_op(2'b10, 8'h05, 8'h07, 4'h4, 8'hFE, 4'b1000);
    send_op(2'b10, 8'h80, 8'h01, 4'h5, 8'h7F, 4'b0011);
    send_op(2'b11, 8'h10, 8'h01, 4'h6, 8'h0F, 4'b0010);
    wait_drain(10);
  endtask

  task automatic test_back_to_back();
    i_ready = 1'b1;
    send_op(2'b00, 8'hFF, 8'h01, 4'h7, 8'h00, 4'b0110);
    send_op(2'b01, 8'h00, 8'h00, 4'h8, 8'h01, 4'b0000);
    send_op(2'b10, 8'h00, 8'h01, 4'h9, 8'hFF, 4'b1000);
    send_op(2'b11, 8'h05, 8'h01, 4'hB, 8'h03, 4'b0010);
    wait_drain(10);
  endtask

  task automatic test_backpressure();
    int n0;
    logic [W:0] snap;
    n0 = n_out;
    i_ready = 1'b0;
    send_op(2'b00, 8'h11, 8'h22, 4'hC, 8'h33, 4'b0000);
    send_op(2'b10, 8'h22, 8'h22, 4'hD, 8'h00, 4'b0110);
    i_valid = 1'b1;
    i_op = 2'b00;
    i_s1 = 8'h7F;
    i_s2 = 8'h01;
    i_tag = 4'hE;
    @(negedge i_clk);
    snap = {o_valid, o_result, o_flags, o_tag};
    repeat (5) begin
      @(negedge i_clk);
      n_vec++;
      if (o_ready !== 1'b0) begin
        n_miss++;
        $display("FAIL bp_ready got=%b expected=0", o_ready);
      end
      n_vec++;
      if ({o_valid, o_result, o_flags, o_tag} !== snap || o_valid !== 1'b1) begin
        n_miss++;
        $display("FAIL bp_stable got=%h expected=%h", {o_valid, o_result, o_flags, o_tag}, snap);
      end
    end
    @(posedge i_clk);
    #1;
    i_ready = 1'b1;
    send_op(2'b00, 8'h7F, 8'h01, 4'hE, 8'h80, 4'b1001);
    wait_drain(10);
    n_vec++;
    if (n_out - n0 != 3) begin
      n_miss++;
      $display("FAIL bp_count got=%0d expected=3", n_out - n0);
    end
  endtask

  task automatic test_throughput();
    int n0;
    int c0;
    n0 = n_out;
    i_ready = 1'b1;
    c0 = cyc;
    for (int i = 0; i < 16; i++) send_rand();
    n_vec++;
    if (cyc - c0 != 16) begin
      n_miss++;
      $display("FAIL throughput got=%0d cycles expected=16", cyc - c0);
    end
    wait_drain(10);
    n_vec++;
    if (n_out - n0 != 16) begin
      n_miss++;
      $display("FAIL tp_count got=%0d expected=16", n_out - n0);
    end
  endtask

  initial begin
    fork
      monitor();
    join_none
    test_reset();
    test_reset_midstream();
    test_add_wrap();
    test_sub();
    test_back_to_back();
    test_backpressure();
    test_throughput();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
